// File: rtl/sevseg_scan_ctrl.sv
// rtl/sevseg_scan_ctrl.sv - 4-digit seven-segment scan controller
// Cycles digit select, feeds the frame-snapshot BCD digit and gates the decoder enable.
module sevseg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 4,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] digits_i,
  input  logic        display_on_i,
  input  logic        lz_blank_i,
  input  logic        adjust_mode_i,
  input  logic [1:0]  adjust_field_i,
  output logic [1:0]  digit_sel_o,
  output logic [3:0]  digit_bcd_o,
  output logic        disp_enable_o,
  output logic        frame_tick_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          en_q, en_d;
  logic          tick_q, tick_d;
  logic [15:0]   snap_q, snap_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic          adj_q;

  logic slot_wrap, frame_wrap, blink_wrap, adj_rise;
  logic in_field, lz_hit, blink_hit;

  // Everything downstream is computed from post-edge values so the enable lines up with sel/bcd.
  always_comb begin
    slot_wrap  = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d      = slot_wrap ? '0 : cnt_q + CW'(1);
    sel_d      = slot_wrap ? sel_q + 2'd1 : sel_q;
    frame_wrap = slot_wrap && (sel_q == 2'd3);
    snap_d     = frame_wrap ? digits_i : snap_q;
    tick_d     = frame_wrap;

    adj_rise   = adjust_mode_i & ~adj_q;
    blink_wrap = (blink_cnt_q == BW'(BLINK_DIV - 1));
    if (adj_rise) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_wrap) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      blink_on_d  = blink_on_q;
    end

    case (sel_d)
      2'd0:    bcd_d = snap_d[3:0];
      2'd1:    bcd_d = snap_d[7:4];
      2'd2:    bcd_d = snap_d[11:8];
      default: bcd_d = snap_d[15:12];
    endcase

    case (adjust_field_i)
      2'd0:    in_field = ~sel_d[1];
      2'd1:    in_field = sel_d[1];
      2'd2:    in_field = 1'b1;
      default: in_field = 1'b0;
    endcase

    lz_hit    = lz_blank_i && (sel_d == 2'd3) && (snap_d[15:12] == 4'd0);
    blink_hit = adjust_mode_i && !blink_on_d && in_field;
    en_d      = display_on_i && (cnt_d >= CW'(DEAD_CYCLES)) && !lz_hit && !blink_hit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      sel_q       <= 2'd0;
      bcd_q       <= 4'd0;
      en_q        <= 1'b0;
      tick_q      <= 1'b0;
      snap_q      <= 16'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      adj_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      bcd_q       <= bcd_d;
      en_q        <= en_d;
      tick_q      <= tick_d;
      snap_q      <= snap_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      adj_q       <= adjust_mode_i;
    end
  end

  assign digit_sel_o   = sel_q;
  assign digit_bcd_o   = bcd_q;
  assign disp_enable_o = en_q;
  assign frame_tick_o  = tick_q;

endmodule

// File: doc/sevseg_scan_ctrl.md
Name: sevseg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display stage. It cycles the digit select, feeds the matching BCD digit, and gates the display enable. Enable gating covers inter-digit dead time, leading-zero blanking and adjust-mode blinking. It sits between the clock/alarm time registers and the seven-segment decoder, and drives that decoder's numbers, sw and enable inputs.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); minimum 4.
DEAD_CYCLES, 4, cycles at the start of each slot with disp_enable forced low (anti-ghosting); must be < REFRESH_DIV.
BLINK_DIV, 25000000, clk cycles per blink half-period (2 Hz full blink at 100 MHz).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
digits  in  16  BCD digits; [3:0] = slot 0 (rightmost) ... [15:12] = slot 3 (leftmost)
display_on  in  1  global display enable
lz_blank  in  1  1 = blank slot 3 when its snapshot digit is 0
adjust_mode  in  1  1 = time/alarm adjust active, selected field blinks
adjust_field  in  2  0 = slots 0-1 (minutes), 1 = slots 2-3 (hours), 2 = all slots, 3 = none
digit_sel  out  2  active slot index, drives decoder sw
digit_bcd  out  4  BCD value for the active slot, drives decoder numbers
disp_enable  out  1  drives decoder enable
frame_tick  out  1  one-cycle pulse on every slot 3 -> slot 0 wrap

Behaviour:
- Reset (rst_n low, async): refresh count = 0, digit_sel = 0, digit_bcd = 0, disp_enable = 0, frame_tick = 0, snapshot = 0, blink count = 0, blink_on = 1, adjust_mode edge register = 0.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the cycle where count == REFRESH_DIV-1, digit_sel increments mod 4 at the next edge.
- Snapshot: a 16-bit register loaded from digits at the edge where digit_sel goes 3 -> 0. All four slots of one frame show a consistent value. The first frame after reset shows the reset snapshot (all 0).
- digit_bcd: registered; equals the snapshot nibble of digit_sel in the same cycle. Values > 9 pass through unchanged.
- frame_tick: high for exactly the one cycle in which digit_sel first equals 0 after a wrap. Not asserted at reset.
- disp_enable: registered and aligned with digit_sel/digit_bcd. It is 1 only when all of the following hold:
  - display_on = 1
  - post-edge refresh count >= DEAD_CYCLES
  - not LZ-blanked: lz_blank = 1 AND digit_sel = 3 AND snapshot[15:12] = 0
  - not blink-blanked: adjust_mode = 1 AND blink_on = 0 AND digit_sel is in the selected field
- Blink timer: counts 0..BLINK_DIV-1; blink_on toggles at each wrap.
  - On a rising edge of adjust_mode, the blink count clears to 0 and blink_on is forced to 1, so the field is visible immediately.
  - While adjust_mode = 0 the timer free-runs but has no effect.
- display_on, lz_blank, adjust_mode and adjust_field act on the next edge. They never disturb the scan sequence or the snapshot.
- Simultaneous events:
  - Slot wrap and blink toggle in the same cycle: both apply.
  - A dead-time slot with a blink-blank: still low.
- Reset mid-frame: everything returns to reset values immediately; scanning restarts at slot 0 with count 0 after release.

Test Plan:
1. REFRESH_DIV=8, DEAD_CYCLES=2, display_on=1, digits=16'h1234, release reset. Frame 1: digit_bcd = 0,0,0,0. From frame 2: slots 0..3 show 4,3,2,1. Each slot lasts 8 cycles, disp_enable low for its first 2 cycles.
2. Same setup; change digits to 16'h5678 mid-slot 1. The rest of the current frame still shows 3,2,1. The next frame shows 8,7,6,5. frame_tick pulses once per 32 cycles, aligned with slot 0 entry.
3. digits=16'h0945, lz_blank=1. disp_enable is never high in slot 3. With lz_blank=0, slot 3 is enabled after dead time and shows 0.
4. BLINK_DIV=16, adjust_mode rises with adjust_field=1. Slots 2-3 are enabled for the first 16 cycles, blanked for the next 16, and so on. Slots 0-1 are unaffected. adjust_field=3 blanks nothing.
5. display_on=0 for a whole frame: disp_enable stays 0, while digit_sel, digit_bcd and frame_tick continue normally.
6. Assert rst_n low mid-slot 2 with disp_enable=1. All outputs go to reset values without waiting for a clock. After release, digit_sel=0 and 8 cycles pass before digit_sel=1.
